// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC-SP13 core.
//   OP_HALT / OP_NOP : 5-bit opcodes (instr[15:11])
//   NOP_INSTR        : encoding used for pipeline bubbles
//   fetch_state_e    : fetch-stage FSM encoding
package wisc_pkg;

  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [4:0]  OP_NOP    = 5'b00001;
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StDiscard = 2'd1,
    StHalted  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc2} skid buffer used to catch a fetch that completes while IF/ID is stalled.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   clear_i           : drop any held entry (highest priority)
//   load_i            : capture instr_i / pc2_i
//   drain_i           : release the held entry
//   instr_o, pc2_o    : held entry
//   valid_o           : entry present
module fetch_skid_buf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc2_i,
  output logic [15:0] instr_o,
  output logic [15:0] pc2_o,
  output logic        valid_o
);

  logic [15:0] instr_q;
  logic [15:0] pc2_q;
  logic        valid_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= 16'h0000;
      pc2_q   <= 16'h0000;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc2_q   <= pc2_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign instr_o = instr_q;
  assign pc2_o   = pc2_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
//   clk, rst_n           : clock, synchronous active-low reset
//   stall                : hold IF/ID (hazard unit)
//   redirect, redirect_pc: taken branch/jump from EX and its target
//   imem_req, imem_addr  : instruction-memory request (held until imem_valid)
//   imem_valid, imem_data: memory response
//   ifid_Instr, ifid_PC2 : instruction and its PC+2 for decode
//   ifid_valid           : 0 when ifid_Instr is a bubble
//   halted               : fetch stopped after a HALT
module fetch_stage import wisc_pkg::*; #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = wisc_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_Instr,
  output logic [15:0] ifid_PC2,
  output logic        ifid_valid,
  output logic        halted
);

  fetch_state_e state_q;
  logic [15:0]  pc_q;
  logic [15:0]  req_addr_q;

  logic [15:0]  buf_instr;
  logic [15:0]  buf_pc2;
  logic         buf_valid;

  logic         accept;
  logic         is_halt;
  logic [15:0]  pc_inc;
  logic [15:0]  target;
  logic         buf_load;
  logic         buf_drain;

  // A full buffer blocks new requests, so a stalled accept always finds it empty.
  assign imem_req  = ((state_q == StFetch) && !buf_valid && rst_n) || (state_q == StDiscard);
  assign imem_addr = req_addr_q;
  assign accept    = imem_req && imem_valid && (state_q == StFetch);
  assign is_halt   = (imem_data[15:11] == OP_HALT);
  assign pc_inc    = pc_q + 16'd2;
  assign target    = redirect_pc & 16'hFFFE;
  assign buf_load  = !redirect && stall && accept;
  assign buf_drain = !redirect && !stall && buf_valid;
  assign halted    = (state_q == StHalted);

  fetch_skid_buf u_skid_buf (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (redirect),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .instr_i (imem_data),
    .pc2_i   (pc_inc),
    .instr_o (buf_instr),
    .pc2_o   (buf_pc2),
    .valid_o (buf_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC & 16'hFFFE;
      req_addr_q <= RESET_PC & 16'hFFFE;
      ifid_Instr <= NOP_INSTR;
      ifid_PC2   <= 16'h0000;
      ifid_valid <= 1'b0;
    end else if (redirect) begin
      ifid_Instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      pc_q       <= target;
      if (imem_req && !imem_valid) begin
        // Old request still in flight: keep its address on the bus until it returns.
        state_q <= StDiscard;
      end else begin
        state_q    <= StFetch;
        req_addr_q <= target;
      end
    end else begin
      if (accept) begin
        pc_q       <= pc_inc;
        req_addr_q <= pc_inc;
        if (is_halt) begin
          state_q <= StHalted;
        end
      end
      if ((state_q == StDiscard) && imem_valid) begin
        req_addr_q <= pc_q;
        state_q    <= StFetch;
      end
      if (!stall) begin
        if (buf_valid) begin
          ifid_Instr <= buf_instr;
          ifid_PC2   <= buf_pc2;
          ifid_valid <= 1'b1;
        end else if (accept) begin
          ifid_Instr <= imem_data;
          ifid_PC2   <= pc_inc;
          ifid_valid <= 1'b1;
        end else begin
          ifid_Instr <= NOP_INSTR;
          ifid_valid <= 1'b0;
        end
      end
    end
  end

endmodule
